// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter.
//   N_REQ         : number of requesters / mux data inputs
//   SEL_W         : width of the mux select {A,B,C}
//   StIdle/StGrant: arbiter state encodings
//   idx_to_onehot : select index -> one-hot grant vector
package mux8_rr_arbiter_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic StIdle  = 1'b0;
  localparam logic StGrant = 1'b1;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_pick.sv
// Combinational round-robin search over eight request lines.
//   req   : request vector
//   start : highest-priority index; search runs upward and wraps 7 -> 0
//   found : at least one request is set
//   idx   : index of the first set request at or after start
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // Rotate so bit 0 of rot is req[start]; the lowest set bit is the winner.
  always_comb begin
    dbl = {req, req} >> start;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int o = N_REQ - 1; o >= 0; o--) begin
      if (rot[o]) off = SEL_W'(o);
    end
    found = |req;
    idx   = start + off;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 single-bit mux.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   req   : per-requester request lines
//   done  : single-cycle release pulse from the current owner
//   gnt   : registered one-hot grant (zero when idle)
//   sel   : mux select {A,B,C}, index of the granted requester; holds when idle
//   valid : grant present
// MAX_HOLD bounds the length of one grant in cycles; 0 disables the bound.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid
);

  localparam int unsigned HoldW    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned HoldLast = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HoldW-1:0] HoldLastW = HoldW'(HoldLast);

  logic             state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic [SEL_W-1:0] owner_next;
  logic [SEL_W-1:0] start;
  logic             expire;
  logic             release_grant;
  logic             found;
  logic [SEL_W-1:0] pick_idx;

  // Searching from owner+1 on release puts a still-requesting owner last.
  assign owner_next    = sel_q + SEL_W'(1);
  assign start         = (state_q == StGrant) ? owner_next : ptr_q;
  assign expire        = (MAX_HOLD != 0) && (hold_q == HoldLastW);
  assign release_grant = (state_q == StGrant) && (!req[sel_q] || done || expire);

  rr_pick8 u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    if (state_q == StIdle) begin
      if (found) begin
        state_d = StGrant;
        gnt_d   = idx_to_onehot(pick_idx);
        sel_d   = pick_idx;
        hold_d  = '0;
      end
    end else if (release_grant) begin
      ptr_d  = owner_next;
      hold_d = '0;
      if (found) begin
        gnt_d = idx_to_onehot(pick_idx);
        sel_d = pick_idx;
      end else begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    end else if (hold_q != HoldLastW) begin
      // With MAX_HOLD=0 HoldLastW is 0, so the counter never moves.
      hold_d = hold_q + HoldW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = |gnt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic [7:0] d_in = 8'h04;  // mux data: only D2 is 1
  logic       p;

  int vectors = 0;
  int miscompares = 0;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid)
  );

  assign p = valid & d_in[sel];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges; leaves time at edge+3.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset and idle
    req = 8'hFF;
    #3;
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    tick();
    chk("rst_hold_gnt", 32'(gnt), 32'h00);
    req = 8'h00;
    rst_n = 1'b1;
    tick();
    chk("idle_gnt", 32'(gnt), 32'h00);
    chk("idle_valid", 32'(valid), 32'h0);

    // Single request on D2
    req = 8'h04;
    tick();
    chk("single_gnt", 32'(gnt), 32'h04);
    chk("single_sel", 32'(sel), 32'h2);
    chk("single_p", 32'(p), 32'h1);
    tick();
    chk("single_gnt2", 32'(gnt), 32'h04);
    req = 8'h00;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h00);
    chk("drop_valid", 32'(valid), 32'h0);
    chk("drop_sel_hold", 32'(sel), 32'h2);
    chk("drop_p", 32'(p), 32'h0);

    // Rotation: all requesting, 4 cycles each, no bubbles
    pulse_reset();
    req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      tick();
      chk($sformatf("rot_gnt_c%0d", c), 32'(gnt), 32'(8'h01 << ((c / 4) % 8)));
      chk($sformatf("rot_sel_c%0d", c), 32'(sel), 32'((c / 4) % 8));
    end

    // Wrap and expiry: owner 7 with req 0 also waiting
    pulse_reset();
    req = 8'h80;
    tick();
    chk("wrap_first", 32'(gnt), 32'h80);
    req = 8'h81;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("wrap_hold%0d", c), 32'(gnt), 32'h80);
    end
    tick();
    chk("wrap_next_gnt", 32'(gnt), 32'h01);
    chk("wrap_next_sel", 32'(sel), 32'h0);

    // Sole owner expires: re-granted with a fresh count
    pulse_reset();
    req = 8'h80;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("solo_gnt%0d", c), 32'(gnt), 32'h80);
    end
    req = 8'h81;  // re-grant happened at last edge; 3 more cycles before release
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("solo_regrant%0d", c), 32'(gnt), 32'h80);
    end
    tick();
    chk("solo_after", 32'(gnt), 32'h01);

    // done pulse: owner 3 hands over to 5
    pulse_reset();
    req = 8'h08;
    tick();
    chk("done_own3", 32'(gnt), 32'h08);
    req = 8'h28;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done_gnt", 32'(gnt), 32'h20);
    chk("done_sel", 32'(sel), 32'h5);
    tick();
    chk("done_stay", 32'(gnt), 32'h20);
    req = 8'h00;
    tick();
    chk("done_idle", 32'(gnt), 32'h00);
    done = 1'b1;
    tick();
    chk("done_idle_nop", 32'(valid), 32'h0);
    req = 8'h02;
    tick();
    done = 1'b0;
    chk("done_idle_grant", 32'(gnt), 32'h02);
    tick();
    chk("done_idle_grant2", 32'(gnt), 32'h02);

    // Async reset mid-grant
    pulse_reset();
    req = 8'h10;
    tick();
    chk("async_pre", 32'(gnt), 32'h10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'h00);
    chk("async_sel", 32'(sel), 32'h0);
    chk("async_valid", 32'(valid), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("async_regrant", 32'(gnt), 32'h10);
    chk("async_regrant_sel", 32'(sel), 32'h4);
    // ptr restarts at 0: with 0 and 4 both requesting after reset, 0 wins
    pulse_reset();
    req = 8'h11;
    tick();
    chk("async_ptr0", 32'(gnt), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 8:1 single-bit multiplexer between eight requesters. It turns request lines into a registered one-hot grant and a matching 3-bit select (A,B,C) for the mux. It bounds how long one owner may hold the mux and rotates priority so no requester starves. It sits between the requesting logic blocks and the mux select inputs.

## Interface
- MAX_HOLD, default 4: maximum consecutive cycles one grant may last; 0 = unlimited (release only by req drop or done).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  8  request per requester; req[i] requests data input Di.
- done  in  1  single-cycle release pulse from the current owner; ignored while valid=0.
- gnt  out  8  one-hot grant, registered; all-zero when idle.
- sel  out  3  mux select {A,B,C}, A = MSB; equals the index of the set gnt bit; holds the last value when idle.
- valid  out  1  high when gnt is non-zero.

## Operation
- Reset values: gnt=0, sel=0, valid=0, ptr=0, hold_cnt=0, state IDLE.
- State IDLE: no owner. If req≠0 at an edge, the winner is taken and the state goes to GRANT at that edge.
- Winner rule: the first set req bit found searching upward from ptr, wrapping 7→0. ptr is the highest-priority index.
- State GRANT: owner k = sel. Release occurs at an edge when any of these holds:
  - req[k]=0,
  - done=1,
  - MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1.
- On release:
  - ptr ← (k+1) mod 8, so the wrap from 7 goes to 0.
  - hold_cnt ← 0.
  - The winner is chosen from req with search start (k+1) mod 8 in the same edge. The result is a back-to-back grant with no idle bubble.
  - If there is no winner, the state goes to IDLE with gnt=0 and valid=0.
- Expired owner still requesting: it is searched last. If it is the only requester, it is re-granted with hold_cnt=0. gnt stays set, sel is unchanged, and the new grant period starts.
- Without release: hold_cnt increments and saturates at MAX_HOLD-1. When MAX_HOLD=0 the counter stays at 0.
- done and a req[k] drop in the same cycle count as one release.
- Requests from non-owners never preempt the owner.
- Invariants:
  - gnt is zero or one-hot.
  - valid == |gnt.
  - When valid=1, sel == index of gnt.
- Width: hold_cnt is ceil(log2(MAX_HOLD+1)) bits, minimum 1.

## Timing
- Latency from request to grant: req set before edge n in IDLE → gnt/sel/valid change just after edge n (registered, 1 cycle).
- Release-to-next-grant latency: 0 extra cycles. The old and new grants switch at the same edge.
- Grant duration with persistent request and no done: exactly MAX_HOLD cycles.
- Combinational paths from inputs to outputs: none. The outputs drive the mux directly, so mux output P is valid in the same cycle as gnt.
- Reset asserted mid-grant: gnt, sel and valid clear immediately (asynchronously). After rst_n deasserts, arbitration restarts from ptr=0 at the first edge.

## Structure
- Shared package holds:
  - N_REQ=8 and SEL_W=3,
  - the state enum {IDLE, GRANT},
  - the function idx_to_onehot.
- One sub-module, rr_pick8, which is combinational. It takes req[7:0] and start[2:0] and returns found and idx[2:0], the first set bit at or after start with wrap.
- Top level holds:
  - the state, ptr, hold_cnt, gnt and sel registers,
  - release logic,
  - a single rr_pick8 instance whose start input is ptr when idle and (k+1) mod 8 on release.

## Test plan
- Reset and idle: rst_n=0 with req=8'hFF → gnt=0, sel=0, valid=0. Release reset with req=8'h00 → outputs stay 0.
- Single request: req=8'b0000_0100 from IDLE → next edge gnt=8'h04, sel=3'b010. Drop req[2] → gnt=0 one edge later. The mux with D2=1 shows P=1 only while granted.
- Rotation with MAX_HOLD=4 and req=8'hFF held: grants go 0,1,2,…,7,0, each lasting exactly 4 cycles, with no idle cycle between them.
- Wrap and expiry: owner 7, req=8'h81, hold expires → gnt=8'h01. Only req[7] set at expiry → gnt stays 8'h80 with hold_cnt reset.
- done pulse: owner 3 with done=1 for one cycle while req=8'h28 → next owner 5 (gnt=8'h20). done pulsed with valid=0 → no effect.
- Async reset mid-grant: assert rst_n=0 between edges while gnt=8'h10 → gnt=0 at once. After release with req=8'h10 → gnt=8'h10 after one edge, search starting from ptr=0.
